cell_volt_uart_tx: RTL and testbench
====================================

# cell_volt_uart_tx

Serial transmitter for the 8-bit cell-voltage fiber link: the transmitting end of the frame format decoded by `uart_8bit`. It takes one byte per valid/ready handshake and shifts it onto an idle-high line as start bit, 8 data bits LSB first, optional parity, and stop bit(s). The block is used in two places: to emulate PIC cell boards in loopback benches, and to forward filtered cell voltages over spare TX fibers. A one-deep holding register allows back-to-back frames with no idle gap.

## Interface
- `BAUD_DIV`, default 434: clk_50 cycles per bit (50 MHz / 115200). Legal range is 2..65535.
- `STOP_BITS`, default 1: number of stop bits per frame, 1 or 2.
- `clk_50`, input, 1: clock.
- `rst`, input, 1: reset, synchronous, active-high. Clock clk_50.
- `tx_data`, input, 8: byte to send. Sampled when the handshake completes.
- `tx_valid`, input, 1: byte offered.
- `tx_ready`, output, 1: holding register empty, so a byte can be accepted.
- `tx_line`, output, 1: serial output, registered, idle high.
- `busy`, output, 1: high when the FSM is not IDLE or the holding register is full.
- `frame_done`, output, 1: one-cycle pulse after the last stop bit completes.

## Operation
- **Handshake.** A transfer happens on a rising edge where `tx_valid && tx_ready`. The byte goes into `hold`, and `hold_full` is set.
- **tx_ready.** `tx_ready = !hold_full`, a combinational function of registered state. It never depends on `tx_valid`.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
- **IDLE.** If `hold_full`, load the shifter from `hold`, clear `hold_full`, and go to START. The clear and the load happen on the same edge.
- **START.** `tx_line = 0` for BAUD_DIV cycles, then go to DATA.
- **DATA.** Output `shift[0]` for BAUD_DIV cycles per bit, shifting right after each bit. The bit counter runs 0..7. After bit 7, go to PARITY if the parity feature is compiled in, otherwise to STOP.
- **PARITY.** Output the even-parity bit for BAUD_DIV cycles, then go to STOP.
- **STOP.** `tx_line = 1` for `STOP_BITS*BAUD_DIV` cycles. On the last cycle:
  - assert `frame_done`;
  - if `hold_full`, load the shifter from `hold` and go straight to START, with no idle bit;
  - otherwise go to IDLE.
- **Accept during a frame.** A new byte can be accepted in any state while `hold_full` is 0.
- **Same-edge accept and drain.** When `hold` drains into the shifter on the same edge as a handshake, the handshake cannot happen, because `tx_ready` was 0 that cycle. This means `hold` is never overwritten.
- **Baud counter.** Counts 0..BAUD_DIV-1 and is forced to 0 on every state transition. The bit boundary is `cnt == BAUD_DIV-1`.
- **Reset.** Reset may arrive in the middle of a frame. It aborts the frame:
  - `tx_line` goes to 1 and the FSM to IDLE;
  - `hold_full` and the counters are cleared;
  - no `frame_done` pulse is generated.
- **Reset values:** `tx_line` = 1, `tx_ready` = 1, `busy` = 0, `frame_done` = 0.

## Timing
- **Latency from idle.** The handshake is sampled at edge N. After edge N+1, `tx_line` = 0 (the start bit).
- **Frame length:** `(1 + 8 + P + STOP_BITS) * BAUD_DIV` cycles, where P is 1 if parity is enabled and 0 otherwise.
- **frame_done.** High for the cycle after the edge that ends the last stop bit. On the same edge `tx_line` either stays 1 (IDLE) or falls to 0 (back-to-back START).
- **tx_ready after a load.** Reasserts the cycle after the hold register is loaded into the shifter, so a second byte can be queued one cycle into the start bit.
- **Glitch-free output.** `tx_line` changes only on bit boundaries and comes from a flop.

## Configuration
- **`CELL_TX_PARITY_EN` defined:**
  - the PARITY state is present;
  - the parity bit is `^data`, which is even parity;
  - the frame is 11 bits with `STOP_BITS`=1.
- **`CELL_TX_PARITY_EN` undefined:**
  - the PARITY state and its logic are absent;
  - the frame is 10 bits, matching the existing `uart_8bit` receivers.

## Structure
- **Shared package `cell_link_pkg`:**
  - FSM state encoding;
  - `DATA_BITS` = 8;
  - `IDLE_LEVEL` = 1'b1;
  - the default baud divisor constant.
- **Sub-module `cell_tx_baud`:** bit-period counter with `clear` and `tick` (tick when `cnt == BAUD_DIV-1`). It is reused by the stop-bit counter logic.

## Test plan
All scenarios use BAUD_DIV=4 and STOP_BITS=1 unless stated otherwise.
- **Single byte.** Send 0xA5 from idle. `tx_line` goes 0, 1,0,1,0,0,1,0,1, 1, each level lasting 4 cycles, and starting 2 edges after the handshake. `frame_done` pulses once at cycle 40, and `busy` then falls.
- **Back-to-back.** Send 0x3C, then 0xFF queued during the 0x3C start bit. The 0xFF start bit follows the 0x3C stop bit with no idle gap, giving two `frame_done` pulses 40 cycles apart. `tx_ready` stays 0 until the 0xFF byte is loaded.
- **Backpressure.** Hold `tx_valid` high with 0x11, 0x22, 0x33 while `tx_ready` is low. Exactly three frames go out, in order, and no byte is dropped or duplicated.
- **Reset mid-frame.** Assert `rst` during data bit 3 of 0x0F. On the next edge `tx_line` = 1, `tx_ready` = 1 and `busy` = 0, and `frame_done` never pulses. A byte sent afterwards produces a clean frame.
- **STOP_BITS=2.** Send 0x80. The stop phase lasts 8 cycles and the frame length is 44 cycles.
- **`CELL_TX_PARITY_EN` defined:**
  - 0xA5: parity bit 0, frame 44 cycles.
  - 0x01: parity bit 1.

Source files
------------

// File: rtl/cell_link_pkg.sv
// rtl/cell_link_pkg.sv - shared constants and state encoding for the cell-voltage fiber link
//
// Contents:
//   tx_state_t        transmitter FSM state encoding
//   DATA_BITS         payload bits per frame
//   IDLE_LEVEL        line level between frames
//   DEFAULT_BAUD_DIV  clk_50 cycles per bit at 115200 baud
//   even_parity()     parity bit that makes the total count of ones even
package cell_link_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    localparam int   DATA_BITS        = 8;
    localparam logic IDLE_LEVEL       = 1'b1;
    localparam int   DEFAULT_BAUD_DIV = 434;

    function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/cell_tx_baud.sv
// rtl/cell_tx_baud.sv - bit-period counter for the cell-voltage transmitter
//
// Ports:
//   clk_50  in   clock
//   rst     in   synchronous active-high reset
//   clear   in   force the count back to 0 (state transitions, idle)
//   tick    out  high during the last cycle of a bit period (cnt == BAUD_DIV-1)
module cell_tx_baud
    import cell_link_pkg::*;
#(
    parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
    input  logic clk_50,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    logic [15:0] cnt;

    assign tick = (cnt == 16'(BAUD_DIV - 1));

    always_ff @(posedge clk_50) begin
        if (rst || clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end

endmodule

// File: rtl/cell_volt_uart_tx.sv
// rtl/cell_volt_uart_tx.sv - 8-bit serial transmitter for the cell-voltage fiber link
//
// Frame: start bit, 8 data bits LSB first, optional even parity, STOP_BITS stop bits.
// Optional feature macro: CELL_TX_PARITY_EN (adds the even-parity bit).
//
// Parameters:
//   BAUD_DIV    clk_50 cycles per bit (2..65535)
//   STOP_BITS   1 or 2
// Ports:
//   clk_50      in   clock
//   rst         in   synchronous active-high reset, aborts any frame in flight
//   tx_data     in   byte to send, captured on the handshake
//   tx_valid    in   byte offered
//   tx_ready    out  holding register empty
//   tx_line     out  registered serial output, idle high
//   busy        out  frame in progress or byte waiting in the holding register
//   frame_done  out  one-cycle pulse after the last stop bit
module cell_volt_uart_tx
    import cell_link_pkg::*;
#(
    parameter int BAUD_DIV  = DEFAULT_BAUD_DIV,
    parameter int STOP_BITS = 1
) (
    input  logic       clk_50,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_line,
    output logic       busy,
    output logic       frame_done
);

    localparam logic STOP_LAST = (STOP_BITS == 2);

    tx_state_t state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] hold_q, hold_d;
    logic                 hold_full_q, hold_full_d;
    logic [2:0]           bit_cnt_q, bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 frame_done_d;
    logic                 line_d;
    logic                 load;
    logic                 tick;
    logic                 baud_clear;
`ifdef CELL_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    // Idle keeps the counter parked at 0 so the start bit gets a full period.
    assign baud_clear = (state_d != state_q) || (state_q == ST_IDLE);

    cell_tx_baud #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud (
        .clk_50 (clk_50),
        .rst    (rst),
        .clear  (baud_clear),
        .tick   (tick)
    );

    assign tx_ready = !hold_full_q;
    assign busy     = (state_q != ST_IDLE) || hold_full_q;

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        hold_d       = hold_q;
        hold_full_d  = hold_full_q;
        bit_cnt_d    = bit_cnt_q;
        stop_cnt_d   = stop_cnt_q;
        frame_done_d = 1'b0;
        load         = 1'b0;
`ifdef CELL_TX_PARITY_EN
        parity_d     = parity_q;
`endif

        if (tx_valid && tx_ready) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (hold_full_q) begin
                    load = 1'b1;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
`ifdef CELL_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                        stop_cnt_d = 1'b0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        shift_d   = shift_q >> 1;
                    end
                end
            end
`ifdef CELL_TX_PARITY_EN
            ST_PARITY: begin
                if (tick) begin
                    state_d    = ST_STOP;
                    stop_cnt_d = 1'b0;
                end
            end
`endif
            ST_STOP: begin
                if (tick) begin
                    if (stop_cnt_q == STOP_LAST) begin
                        frame_done_d = 1'b1;
                        if (hold_full_q) begin
                            load = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A load only happens with hold_full set, so tx_ready was low and no
        // handshake can collide with the drain on this edge.
        if (load) begin
            state_d     = ST_START;
            shift_d     = hold_q;
            hold_full_d = 1'b0;
`ifdef CELL_TX_PARITY_EN
            parity_d    = even_parity(hold_q);
`endif
        end
    end

    // The line level is decoded from the next state so the output flop
    // changes on exactly the edge the FSM crosses a bit boundary.
    always_comb begin
        line_d = IDLE_LEVEL;
        case (state_d)
            ST_START: line_d = 1'b0;
            ST_DATA:  line_d = shift_d[0];
`ifdef CELL_TX_PARITY_EN
            ST_PARITY: line_d = parity_d;
`endif
            default:  line_d = IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clk_50) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            bit_cnt_q   <= '0;
            stop_cnt_q  <= 1'b0;
            frame_done  <= 1'b0;
            tx_line     <= IDLE_LEVEL;
`ifdef CELL_TX_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            bit_cnt_q   <= bit_cnt_d;
            stop_cnt_q  <= stop_cnt_d;
            frame_done  <= frame_done_d;
            tx_line     <= line_d;
`ifdef CELL_TX_PARITY_EN
            parity_q    <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_cell_volt_uart_tx.sv
// tb/tb_cell_volt_uart_tx.sv - self-checking bench for cell_volt_uart_tx
module tb_cell_volt_uart_tx;

    localparam int BD = 4;
`ifdef CELL_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int NB1 = 10 + P;
    localparam int FL1 = NB1 * BD;
    localparam int NB2 = 11 + P;
    localparam int FL2 = NB2 * BD;

    logic       clk_50 = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid, tx_valid2;
    logic       tx_ready, tx_line, busy, frame_done;
    logic       tx_ready2, tx_line2, busy2, frame_done2;

    int n_tests = 0;
    int n_fail  = 0;

    logic ln1 [0:299];
    logic fd1 [0:299];
    logic rd1 [0:299];
    logic bz1 [0:299];
    logic ln2 [0:299];
    logic fd2 [0:299];

    typedef struct {
        logic [7:0] data;
        logic       par;
    } vec_t;
    vec_t vecs [5];

    always #10 clk_50 = ~clk_50;

    cell_volt_uart_tx #(.BAUD_DIV(BD), .STOP_BITS(1)) u_dut (
        .clk_50     (clk_50),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_line    (tx_line),
        .busy       (busy),
        .frame_done (frame_done)
    );

    cell_volt_uart_tx #(.BAUD_DIV(BD), .STOP_BITS(2)) u_dut2 (
        .clk_50     (clk_50),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid2),
        .tx_ready   (tx_ready2),
        .tx_line    (tx_line2),
        .busy       (busy2),
        .frame_done (frame_done2)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // sample index k holds the outputs seen after the k-th rising edge
    // following the first sample point
    task automatic capture(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk_50);
            ln1[k] = tx_line;
            fd1[k] = frame_done;
            rd1[k] = tx_ready;
            bz1[k] = busy;
            ln2[k] = tx_line2;
            fd2[k] = frame_done2;
        end
    endtask

    function automatic logic exp_level(input logic [7:0] d, input logic p, input int b);
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        if (P == 1 && b == 9) return p;
        return 1'b1;
    endfunction

    task automatic chk_frame(input string nm, input bit sel, input int start,
                             input logic [7:0] d, input logic p, input int nbits);
        for (int b = 0; b < nbits; b++) begin
            logic [3:0] act;
            logic [3:0] expv;
            for (int c = 0; c < BD; c++) begin
                act[c] = sel ? ln2[start + b*BD + c] : ln1[start + b*BD + c];
            end
            expv = {4{exp_level(d, p, b)}};
            chk($sformatf("%s_bit%0d", nm, b), {28'd0, act}, {28'd0, expv});
        end
    endtask

    function automatic int count_fd(input bit sel, input int lo, input int hi);
        int n = 0;
        for (int k = lo; k <= hi; k++) begin
            if (sel ? fd2[k] : fd1[k]) n++;
        end
        return n;
    endfunction

    task automatic run_single(input string nm, input logic [7:0] d, input logic p);
        @(negedge clk_50);
        tx_data  = d;
        tx_valid = 1'b1;
        fork
            begin
                @(negedge clk_50);
                tx_valid = 1'b0;
            end
            capture(FL1 + 4);
        join
        chk({nm, "_line_before_start"}, {31'd0, ln1[0]}, 32'd1);
        chk({nm, "_ready_after_accept"}, {31'd0, rd1[0]}, 32'd0);
        chk({nm, "_busy_after_accept"}, {31'd0, bz1[0]}, 32'd1);
        chk_frame(nm, 1'b0, 1, d, p, NB1);
        chk({nm, "_done_at_end"}, {31'd0, fd1[1 + FL1]}, 32'd1);
        chk({nm, "_done_count"}, count_fd(1'b0, 0, FL1 + 3), 32'd1);
        chk({nm, "_busy_last_stop"}, {31'd0, bz1[FL1]}, 32'd1);
        chk({nm, "_busy_after_done"}, {31'd0, bz1[1 + FL1]}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] bp [3];
        int zeros;
        int lowrdy;

        vecs[0] = '{data: 8'hA5, par: 1'b0};
        vecs[1] = '{data: 8'h01, par: 1'b1};
        vecs[2] = '{data: 8'h00, par: 1'b0};
        vecs[3] = '{data: 8'hFF, par: 1'b0};
        vecs[4] = '{data: 8'h80, par: 1'b1};

        rst       = 1'b1;
        tx_data   = 8'h00;
        tx_valid  = 1'b0;
        tx_valid2 = 1'b0;
        repeat (3) @(negedge clk_50);
        chk("rst_line", {31'd0, tx_line}, 32'd1);
        chk("rst_ready", {31'd0, tx_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, frame_done}, 32'd0);
        chk("rst_line2", {31'd0, tx_line2}, 32'd1);
        rst = 1'b0;
        repeat (2) @(negedge clk_50);

        // single frames from idle
        for (int i = 0; i < 5; i++) begin
            run_single($sformatf("single%0d", i), vecs[i].data, vecs[i].par);
        end

        // back-to-back: 0xFF queued during the 0x3C start bit
        @(negedge clk_50);
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
        fork
            begin
                @(negedge clk_50);
                tx_valid = 1'b0;
                @(negedge clk_50);
                tx_data  = 8'hFF;
                tx_valid = 1'b1;
                @(negedge clk_50);
                tx_valid = 1'b0;
            end
            capture(2*FL1 + 5);
        join
        chk("b2b_ready_full", {31'd0, rd1[0]}, 32'd0);
        chk("b2b_ready_after_load", {31'd0, rd1[1]}, 32'd1);
        lowrdy = 0;
        for (int k = 2; k <= FL1; k++) if (rd1[k]) lowrdy++;
        chk("b2b_ready_held_low", lowrdy, 32'd0);
        chk("b2b_ready_after_second_load", {31'd0, rd1[1 + FL1]}, 32'd1);
        chk_frame("b2b_a", 1'b0, 1, 8'h3C, 1'b0, NB1);
        chk_frame("b2b_b", 1'b0, 1 + FL1, 8'hFF, 1'b0, NB1);
        chk("b2b_done_a", {31'd0, fd1[1 + FL1]}, 32'd1);
        chk("b2b_done_b", {31'd0, fd1[1 + 2*FL1]}, 32'd1);
        chk("b2b_done_count", count_fd(1'b0, 0, 2*FL1 + 4), 32'd2);

        // backpressure: tx_valid held high across three bytes
        bp[0] = 8'h11;
        bp[1] = 8'h22;
        bp[2] = 8'h33;
        @(negedge clk_50);
        tx_data  = bp[0];
        tx_valid = 1'b1;
        fork
            begin
                for (int i = 0; i < 3; i++) begin
                    int   guard;
                    logic ok;
                    guard   = 0;
                    ok      = 1'b0;
                    tx_data = bp[i];
                    while (!ok && guard < 200) begin
                        ok = tx_ready;
                        @(negedge clk_50);
                        guard++;
                    end
                    if (!ok) chk($sformatf("bp_accept_timeout%0d", i), 32'd0, 32'd1);
                end
                tx_valid = 1'b0;
            end
            capture(3*FL1 + 5);
        join
        chk_frame("bp_0", 1'b0, 1, 8'h11, 1'b0, NB1);
        chk_frame("bp_1", 1'b0, 1 + FL1, 8'h22, 1'b0, NB1);
        chk_frame("bp_2", 1'b0, 1 + 2*FL1, 8'h33, 1'b0, NB1);
        chk("bp_done_count", count_fd(1'b0, 0, 3*FL1 + 4), 32'd3);
        chk("bp_done_last", {31'd0, fd1[1 + 3*FL1]}, 32'd1);
        chk("bp_idle_after", {31'd0, bz1[1 + 3*FL1]}, 32'd0);

        // reset during data bit 3 of 0x0F
        @(negedge clk_50);
        tx_data  = 8'h0F;
        tx_valid = 1'b1;
        @(negedge clk_50);
        tx_valid = 1'b0;
        repeat (17) @(negedge clk_50);
        rst = 1'b1;
        @(negedge clk_50);
        chk("midrst_line", {31'd0, tx_line}, 32'd1);
        chk("midrst_ready", {31'd0, tx_ready}, 32'd1);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, frame_done}, 32'd0);
        rst = 1'b0;
        capture(60);
        chk("midrst_no_done", count_fd(1'b0, 0, 59), 32'd0);
        zeros = 0;
        for (int k = 0; k < 60; k++) if (!ln1[k]) zeros++;
        chk("midrst_line_idle", zeros, 32'd0);
        run_single("after_rst", 8'hA5, 1'b0);

        // two stop bits on the second instance
        @(negedge clk_50);
        tx_data   = 8'h80;
        tx_valid2 = 1'b1;
        fork
            begin
                @(negedge clk_50);
                tx_valid2 = 1'b0;
            end
            capture(FL2 + 4);
        join
        chk("stop2_line_before_start", {31'd0, ln2[0]}, 32'd1);
        chk_frame("stop2", 1'b1, 1, 8'h80, 1'b1, NB2);
        chk("stop2_done_at_end", {31'd0, fd2[1 + FL2]}, 32'd1);
        chk("stop2_done_count", count_fd(1'b1, 0, FL2 + 3), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
